// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC / instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

endpackage

// File: rtl/pc_fetch_ctrl_flopenr.sv
// Enable register with asynchronous active-low reset to a fixed value.
module flopenr #(
    parameter int           N       = 8,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and instruction-memory fetch controller for the front end.
// Optional fetch timeout fault enabled by defining FETCH_TIMEOUT_EN.
import fetch_pkg::*;

module pc_fetch_ctrl #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_o,
    output logic [N-1:0]       imem_addr_o,
    input  logic               imem_ready_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [N-1:0]       pc_o,
    input  logic               stall_i,
    input  logic               br_taken_i,
    input  logic [N-1:0]       br_target_i,
    output logic               fault_o
);

    if (N < 2) begin : g_bad_n
        $error("pc_fetch_ctrl: N must be at least 2");
    end
    if (MAX_WAIT < 1) begin : g_bad_wait
        $error("pc_fetch_ctrl: MAX_WAIT must be at least 1");
    end

    fetch_state_t state;
    fetch_state_t state_next;

    logic [N-1:0] pc;
    logic [N-1:0] pc_next;
    logic         consume;
    logic         misaligned;
    logic         pc_en;
    logic         capture;
    logic         timeout;

    assign consume    = (state == S_VALID) && !stall_i;
    assign misaligned = consume && br_taken_i && (br_target_i[1:0] != 2'b00);
    assign pc_en      = consume && !misaligned;
    assign pc_next    = br_taken_i ? br_target_i : pc + N'(PC_INC);
    assign capture    = (state == S_FETCH) && imem_ready_i;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt;

    // Fires on the MAX_WAIT-th consecutive cycle without ready.
    assign timeout = (state == S_FETCH) && !imem_ready_i
                  && (wait_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state == S_FETCH) && !imem_ready_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_BOOT: state_next = S_FETCH;
            S_FETCH: begin
                if (capture) begin
                    state_next = S_VALID;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_VALID: begin
                if (misaligned) begin
                    state_next = S_FAULT;
                end else if (consume) begin
                    state_next = S_FETCH;
                end
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    flopenr #(
        .N       (N),
        .RST_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .rst_n (reset),
        .en    (pc_en),
        .d     (pc_next),
        .q     (pc)
    );

    flopenr #(
        .N       (INSTR_W + N),
        .RST_VAL ('0)
    ) u_instr (
        .clk   (clk),
        .rst_n (reset),
        .en    (capture),
        .d     ({imem_rdata_i, pc}),
        .q     ({instr_o, pc_o})
    );

    assign imem_req_o    = (state == S_FETCH);
    assign imem_addr_o   = pc;
    assign instr_valid_o = (state == S_VALID);
    assign fault_o       = (state == S_FAULT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

    localparam int N = 64;

    logic          clk;
    logic          reset;
    logic          imem_req;
    logic [N-1:0]  imem_addr;
    logic          imem_ready;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [N-1:0]  pc;
    logic          stall;
    logic          br_taken;
    logic [N-1:0]  br_target;
    logic          fault;

    int pass_cnt = 0;
    int total_cnt = 0;

    pc_fetch_ctrl #(
        .N        (N),
        .RESET_PC ('0),
        .MAX_WAIT (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ready_i  (imem_ready),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .pc_o          (pc),
        .stall_i       (stall),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .fault_o       (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;

        #12;
        check("rst_req",   64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);

        tick();
        reset = 1'b1;
        check("boot_req", 64'(imem_req), 64'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0093;

        tick();
        check("f0_req",  64'(imem_req), 64'd1);
        check("f0_addr", imem_addr, 64'h0);
        tick();
        check("v0_valid", 64'(instr_valid), 64'd1);
        check("v0_req",   64'(imem_req), 64'd0);
        check("v0_pc",    pc, 64'h0);
        check("v0_instr", 64'(instr), 64'h93);
        imem_rdata = 32'h0010_0113;
        tick();
        check("f1_addr", imem_addr, 64'h4);
        tick();
        check("v1_pc",    pc, 64'h4);
        check("v1_instr", 64'(instr), 64'h0010_0113);
        tick();
        check("f2_addr", imem_addr, 64'h8);

        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dly_req",  64'(imem_req), 64'd1);
            check("dly_addr", imem_addr, 64'h8);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        check("dly_valid", 64'(instr_valid), 64'd1);
        check("dly_pc",    pc, 64'h8);
        check("dly_instr", 64'(instr), 64'h1234_5678);

        stall     = 1'b1;
        br_taken  = 1'b1;
        br_target = 64'h100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stl_valid", 64'(instr_valid), 64'd1);
            check("stl_req",   64'(imem_req), 64'd0);
            check("stl_pc",    pc, 64'h8);
        end
        stall = 1'b0;
        tick();
        check("br_req",  64'(imem_req), 64'd1);
        check("br_addr", imem_addr, 64'h100);
        br_taken   = 1'b0;
        imem_rdata = 32'h0000_0013;
        tick();
        check("br_pc", pc, 64'h100);

        br_taken  = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        check("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        br_taken = 1'b0;
        tick();
        check("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_addr", imem_addr, 64'h0);
        tick();
        check("wrap_pc", pc, 64'h0);

        br_taken  = 1'b1;
        br_target = 64'h102;
        tick();
        check("mis_fault", 64'(fault), 64'd1);
        check("mis_req",   64'(imem_req), 64'd0);
        check("mis_valid", 64'(instr_valid), 64'd0);
        check("mis_pc",    pc, 64'h0);
        check("mis_addr",  imem_addr, 64'h0);
        br_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flt_hold", 64'(fault), 64'd1);
            check("flt_req",  64'(imem_req), 64'd0);
        end

        reset = 1'b0;
        #1;
        check("clr_fault", 64'(fault), 64'd0);
        reset = 1'b1;
        tick();
        check("rs_req",  64'(imem_req), 64'd1);
        check("rs_addr", imem_addr, 64'h0);
        imem_ready = 1'b0;
        tick();
        check("mid_req", 64'(imem_req), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_drop", 64'(imem_req), 64'd0);
        reset = 1'b1;
        check("mid_boot", 64'(imem_req), 64'd0);
        tick();
        check("re_req",  64'(imem_req), 64'd1);
        check("re_addr", imem_addr, 64'h0);

`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        check("to_pre",     64'(fault), 64'd0);
        check("to_pre_req", 64'(imem_req), 64'd1);
        tick();
        check("to_fault", 64'(fault), 64'd1);

        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        imem_ready = 1'b1;
        tick();
        check("to_late_valid", 64'(instr_valid), 64'd1);
        check("to_late_fault", 64'(fault), 64'd0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("nto_fault", 64'(fault), 64'd0);
        check("nto_req",   64'(imem_req), 64'd1);
        check("nto_addr",  imem_addr, 64'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
